// File: rtl/lc4_dx_if.sv
// lc4_dx_if: signal bundle for the LC4 D->X pipeline register.
//   gwe              global write enable
//   i_d_*            decode-stage instruction, register indices and read data
//   i_m_*, i_w_*     M/W destination info and results used for bypassing
//   i_flush          mispredict kill from X
//   o_d_stall        hold F and D
//   o_x_*            execute-stage instruction and bypassed operands
//   o_perf_*         performance counters (only when LC4_DX_PERF_EN is defined)
// Modports: slave = the stage itself, master = whoever drives it.
interface lc4_dx_if;
  logic        gwe;
  logic        i_d_valid;
  logic [15:0] i_d_insn;
  logic [15:0] i_d_pc;
  logic [2:0]  i_d_rs;
  logic [2:0]  i_d_rt;
  logic        i_d_rs_re;
  logic        i_d_rt_re;
  logic [2:0]  i_d_rd;
  logic        i_d_we;
  logic        i_d_is_load;
  logic        i_d_is_store;
  logic [15:0] i_d_r1data;
  logic [15:0] i_d_r2data;
  logic [2:0]  i_m_rd;
  logic        i_m_we;
  logic [15:0] i_m_result;
  logic [2:0]  i_w_rd;
  logic        i_w_we;
  logic [15:0] i_w_result;
  logic        i_flush;
  logic        o_d_stall;
  logic        o_x_valid;
  logic [15:0] o_x_insn;
  logic [15:0] o_x_pc;
  logic [15:0] o_x_r1data;
  logic [15:0] o_x_r2data;
  logic [2:0]  o_x_rd;
  logic        o_x_we;
  logic        o_x_is_load;
`ifdef LC4_DX_PERF_EN
  logic [15:0] o_perf_lu_cnt;
  logic [15:0] o_perf_div_cnt;
`endif

  modport slave (
    input  gwe, i_d_valid, i_d_insn, i_d_pc, i_d_rs, i_d_rt, i_d_rs_re, i_d_rt_re,
           i_d_rd, i_d_we, i_d_is_load, i_d_is_store, i_d_r1data, i_d_r2data,
           i_m_rd, i_m_we, i_m_result, i_w_rd, i_w_we, i_w_result, i_flush,
    output o_d_stall, o_x_valid, o_x_insn, o_x_pc, o_x_r1data, o_x_r2data,
           o_x_rd, o_x_we, o_x_is_load
`ifdef LC4_DX_PERF_EN
    , output o_perf_lu_cnt, o_perf_div_cnt
`endif
  );

  modport master (
    output gwe, i_d_valid, i_d_insn, i_d_pc, i_d_rs, i_d_rt, i_d_rs_re, i_d_rt_re,
           i_d_rd, i_d_we, i_d_is_load, i_d_is_store, i_d_r1data, i_d_r2data,
           i_m_rd, i_m_we, i_m_result, i_w_rd, i_w_we, i_w_result, i_flush,
    input  o_d_stall, o_x_valid, o_x_insn, o_x_pc, o_x_r1data, o_x_r2data,
           o_x_rd, o_x_we, o_x_is_load
`ifdef LC4_DX_PERF_EN
    , input o_perf_lu_cnt, o_perf_div_cnt
`endif
  );
endinterface

// File: rtl/lc4_dx_stage.sv
// lc4_dx_stage: D->X pipeline register of the LC4 pipeline.
// Handles load-use stalls, multi-cycle DIV/MOD occupancy of X, mispredict
// flush and MX/WX operand bypass. Bubbles are insn 16'h0000 with valid=0.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   dx    lc4_dx_if.slave (D inputs, M/W bypass, flush, X outputs)
// Parameter DIV_LAT: cycles a DIV/MOD occupies X (1 = no extra occupancy).
// Optional: define LC4_DX_PERF_EN to add load-use and BUSY cycle counters.
//
// state | meaning
// IDLE  | X advances normally each gwe edge
// BUSY  | DIV/MOD held in X, cnt_q cycles remaining before it completes
module lc4_dx_stage #(
  parameter int DIV_LAT = 4
) (
  input logic    clk,
  input logic    rst,
  lc4_dx_if.slave dx
);

  localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [15:0]   insn_q, insn_d;
  logic [15:0]   pc_q, pc_d;
  logic [2:0]    rs_q, rs_d;
  logic [2:0]    rt_q, rt_d;
  logic [15:0]   r1_q, r1_d;
  logic [15:0]   r2_q, r2_d;
  logic [2:0]    rd_q, rd_d;
  logic          we_q, we_d;
  logic          is_load_q, is_load_d;

  logic [15:0]   r1_byp, r2_byp;
  logic          load_use;
  logic          enter_busy;
  logic          lu_bubble;
  logic          busy_cycle;

  function automatic logic is_div_mod(input logic [15:0] insn);
    return ((insn[15:12] == 4'b0001) && (insn[5:3] == 3'b011)) ||
           ((insn[15:12] == 4'b1010) && (insn[5:4] == 2'b11));
  endfunction

  always_comb begin
    r1_byp = r1_q;
    if (dx.i_m_we && (dx.i_m_rd == rs_q))      r1_byp = dx.i_m_result;
    else if (dx.i_w_we && (dx.i_w_rd == rs_q)) r1_byp = dx.i_w_result;
    r2_byp = r2_q;
    if (dx.i_m_we && (dx.i_m_rd == rt_q))      r2_byp = dx.i_m_result;
    else if (dx.i_w_we && (dx.i_w_rd == rt_q)) r2_byp = dx.i_w_result;
  end

  // Stores read rt as data, which can still be bypassed in X, so rt only
  // causes a load-use stall for non-store consumers.
  assign load_use = valid_q && is_load_q &&
                    ((dx.i_d_rs_re && (dx.i_d_rs == rd_q)) ||
                     (dx.i_d_rt_re && !dx.i_d_is_store && (dx.i_d_rt == rd_q)));

  assign enter_busy = (DIV_LAT > 1) && dx.i_d_valid && is_div_mod(dx.i_d_insn);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    insn_d     = insn_q;
    pc_d       = pc_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    rd_d       = rd_q;
    we_d       = we_q;
    is_load_d  = is_load_q;
    lu_bubble  = 1'b0;
    busy_cycle = 1'b0;
    if (dx.gwe) begin
      if (dx.i_flush || (state_q == IDLE && load_use)) begin
        lu_bubble = !dx.i_flush;
        state_d   = IDLE;
        cnt_d     = '0;
        valid_d   = 1'b0;
        insn_d    = '0;
        pc_d      = '0;
        rs_d      = '0;
        rt_d      = '0;
        r1_d      = '0;
        r2_d      = '0;
        rd_d      = '0;
        we_d      = 1'b0;
        is_load_d = 1'b0;
      end else if (state_q == BUSY) begin
        // Operands track late M/W producers while the divide is held.
        busy_cycle = 1'b1;
        r1_d       = r1_byp;
        r2_d       = r2_byp;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end else begin
        valid_d   = dx.i_d_valid;
        insn_d    = dx.i_d_insn;
        pc_d      = dx.i_d_pc;
        rs_d      = dx.i_d_rs;
        rt_d      = dx.i_d_rt;
        r1_d      = dx.i_d_r1data;
        r2_d      = dx.i_d_r2data;
        rd_d      = dx.i_d_rd;
        we_d      = dx.i_d_we && dx.i_d_valid;
        is_load_d = dx.i_d_is_load && dx.i_d_valid;
        if (enter_busy) begin
          state_d = BUSY;
          cnt_d   = CW'(DIV_LAT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      insn_q    <= '0;
      pc_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      insn_q    <= insn_d;
      pc_q      <= pc_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      is_load_q <= is_load_d;
    end
  end

  // Bypass muxes are combinational, so they are forced low during reset.
  assign dx.o_d_stall   = !rst && !dx.i_flush && (load_use || state_q == BUSY);
  assign dx.o_x_valid   = valid_q && (state_q == IDLE);
  assign dx.o_x_insn    = insn_q;
  assign dx.o_x_pc      = pc_q;
  assign dx.o_x_r1data  = rst ? 16'h0000 : r1_byp;
  assign dx.o_x_r2data  = rst ? 16'h0000 : r2_byp;
  assign dx.o_x_rd      = rd_q;
  assign dx.o_x_we      = we_q && (state_q == IDLE);
  assign dx.o_x_is_load = is_load_q;

`ifdef LC4_DX_PERF_EN
  logic [15:0] lu_cnt_q, lu_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;

  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    div_cnt_d = div_cnt_q;
    if (lu_bubble && lu_cnt_q != 16'hFFFF)    lu_cnt_d  = lu_cnt_q + 16'd1;
    if (busy_cycle && div_cnt_q != 16'hFFFF)  div_cnt_d = div_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      div_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign dx.o_perf_lu_cnt  = lu_cnt_q;
  assign dx.o_perf_div_cnt = div_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = lu_bubble ^ busy_cycle;
`endif

endmodule
